// File: rtl/tpu_pkg.sv
// Shared definitions for the 2x2 systolic array control path: sequencer
// state encoding, operand-select codes and accumulator width.
package tpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_FEED0   = 3'd2,
    ST_FEED1   = 3'd3,
    ST_FEED2   = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_CAPTURE = 3'd6
  } state_e;

  localparam logic [1:0] SEL_W0   = 2'd0;
  localparam logic [1:0] SEL_W1   = 2'd1;
  localparam logic [1:0] SEL_ZERO = 2'd2;

  localparam int ACC_W = 16;

endpackage

// File: rtl/systolic_sequencer_2x2.sv
// Job sequencer for the 2x2 systolic array: clear, three skewed feed cycles,
// drain, then capture of the accumulators behind a valid/ready result port.
module systolic_sequencer_2x2
  import tpu_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    transpose_req,
  input  logic                    relu_req,
  output logic                    start_ready,
  output logic                    busy,
  output logic                    clear,
  output logic                    data_valid,
  output logic [1:0]              a0_sel,
  output logic [1:0]              a1_sel,
  output logic [1:0]              b0_sel,
  output logic [1:0]              b1_sel,
  output logic                    transpose,
  output logic                    activation,
  input  logic signed [ACC_W-1:0] c00,
  input  logic signed [ACC_W-1:0] c01,
  input  logic signed [ACC_W-1:0] c10,
  input  logic signed [ACC_W-1:0] c11,
  output logic signed [ACC_W-1:0] res00,
  output logic signed [ACC_W-1:0] res01,
  output logic signed [ACC_W-1:0] res10,
  output logic signed [ACC_W-1:0] res11,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    transpose_q, transpose_d;
  logic                    activation_q, activation_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0] res00_q, res00_d;
  logic signed [ACC_W-1:0] res01_q, res01_d;
  logic signed [ACC_W-1:0] res10_q, res10_d;
  logic signed [ACC_W-1:0] res11_q, res11_d;

  assign start_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign busy        = (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    transpose_d  = transpose_q;
    activation_d = activation_q;
    out_valid_d  = out_valid_q;
    res00_d      = res00_q;
    res01_d      = res01_q;
    res10_d      = res10_q;
    res11_d      = res11_q;
    clear        = 1'b0;
    data_valid   = 1'b0;
    a0_sel       = SEL_ZERO;
    a1_sel       = SEL_ZERO;
    b0_sel       = SEL_ZERO;
    b1_sel       = SEL_ZERO;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && start_ready) begin
          state_d      = ST_CLEAR;
          transpose_d  = transpose_req;
          activation_d = relu_req;
        end
      end
      ST_CLEAR: begin
        clear   = 1'b1;
        state_d = ST_FEED0;
      end
      // Row/column 1 lag row/column 0 by one cycle to form the systolic skew.
      ST_FEED0: begin
        data_valid = 1'b1;
        a0_sel     = SEL_W0;
        b0_sel     = SEL_W0;
        state_d    = ST_FEED1;
      end
      ST_FEED1: begin
        data_valid = 1'b1;
        a0_sel     = SEL_W1;
        a1_sel     = SEL_W0;
        b0_sel     = SEL_W1;
        b1_sel     = SEL_W0;
        state_d    = ST_FEED2;
      end
      ST_FEED2: begin
        data_valid = 1'b1;
        a1_sel     = SEL_W1;
        b1_sel     = SEL_W1;
        cnt_d      = CNT_W'(DRAIN_CYCLES - 1);
        state_d    = ST_DRAIN;
      end
      // The CAPTURE cycle is the last drain cycle, so leave DRAIN as the
      // counter steps from 1 to 0.
      ST_DRAIN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        res00_d     = c00;
        res01_d     = c01;
        res10_d     = c10;
        res11_d     = c11;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      transpose_q  <= 1'b0;
      activation_q <= 1'b0;
      out_valid_q  <= 1'b0;
      res00_q      <= '0;
      res01_q      <= '0;
      res10_q      <= '0;
      res11_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      transpose_q  <= transpose_d;
      activation_q <= activation_d;
      out_valid_q  <= out_valid_d;
      res00_q      <= res00_d;
      res01_q      <= res01_d;
      res10_q      <= res10_d;
      res11_q      <= res11_d;
    end
  end

  assign transpose  = transpose_q;
  assign activation = activation_q;
  assign out_valid  = out_valid_q;
  assign res00      = res00_q;
  assign res01      = res01_q;
  assign res10      = res10_q;
  assign res11      = res11_q;

endmodule

// File: tb/tb_systolic_sequencer_2x2.sv
// Directed bench for systolic_sequencer_2x2 driving a behavioural 2x2
// output-stationary array model from the sequencer's control pins.
module tb_systolic_sequencer_2x2;

  logic clk = 1'b0;
  logic rst, start, transpose_req, relu_req, out_ready;
  logic start_ready, busy, clear, data_valid, transpose, activation, out_valid;
  logic [1:0] a0_sel, a1_sel, b0_sel, b1_sel;
  logic signed [15:0] c00, c01, c10, c11, res00, res01, res10, res11;

  logic start4;
  logic start_ready4, busy4, clear4, dv4, tr4, act4, ov4;
  logic [1:0] a0s4, a1s4, b0s4, b1s4;
  logic signed [15:0] r00_4, r01_4, r10_4, r11_4;
  logic signed [15:0] zero16 = 16'sd0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  systolic_sequencer_2x2 #(.DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .transpose_req(transpose_req),
    .relu_req(relu_req), .start_ready(start_ready), .busy(busy), .clear(clear),
    .data_valid(data_valid), .a0_sel(a0_sel), .a1_sel(a1_sel), .b0_sel(b0_sel),
    .b1_sel(b1_sel), .transpose(transpose), .activation(activation),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11),
    .res00(res00), .res01(res01), .res10(res10), .res11(res11),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  systolic_sequencer_2x2 #(.DRAIN_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .transpose_req(1'b0),
    .relu_req(1'b0), .start_ready(start_ready4), .busy(busy4), .clear(clear4),
    .data_valid(dv4), .a0_sel(a0s4), .a1_sel(a1s4), .b0_sel(b0s4),
    .b1_sel(b1s4), .transpose(tr4), .activation(act4),
    .c00(zero16), .c01(zero16), .c10(zero16), .c11(zero16),
    .res00(r00_4), .res01(r01_4), .res10(r10_4), .res11(r11_4),
    .out_valid(ov4), .out_ready(1'b1)
  );

  // Array model: A rows enter from the left, B columns from the top.
  logic signed [15:0] ma [0:1][0:1];
  logic signed [15:0] mb [0:1][0:1];
  logic signed [15:0] acc00 = 0, acc01 = 0, acc10 = 0, acc11 = 0;
  logic signed [15:0] a0d = 0, a1d = 0, b0d = 0, b1d = 0;
  logic signed [15:0] a0v, a1v, b0v, b1v;

  function automatic logic signed [15:0] bus_a(input int i, input logic [1:0] s);
    if (s >= 2'd2) return 16'sd0;
    return ma[i][int'(s)];
  endfunction

  function automatic logic signed [15:0] bus_b(input int j, input logic [1:0] s, input logic tr);
    if (s >= 2'd2) return 16'sd0;
    return tr ? mb[j][int'(s)] : mb[int'(s)][j];
  endfunction

  always_comb begin
    a0v = bus_a(0, a0_sel);
    a1v = bus_a(1, a1_sel);
    b0v = bus_b(0, b0_sel, transpose);
    b1v = bus_b(1, b1_sel, transpose);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      acc00 <= 0; acc01 <= 0; acc10 <= 0; acc11 <= 0;
    end else begin
      acc00 <= acc00 + 16'(a0v * b0v);
      acc01 <= acc01 + 16'(a0d * b1v);
      acc10 <= acc10 + 16'(a1v * b0d);
      acc11 <= acc11 + 16'(a1d * b1d);
    end
    a0d <= a0v; a1d <= a1v; b0d <= b0v; b1d <= b1v;
  end

  assign c00 = (activation && acc00 < 0) ? 16'sd0 : acc00;
  assign c01 = (activation && acc01 < 0) ? 16'sd0 : acc01;
  assign c10 = (activation && acc10 < 0) ? 16'sd0 : acc10;
  assign c11 = (activation && acc11 < 0) ? 16'sd0 : acc11;

  task automatic set_mats(input int a00, a01, a10, a11, b00, b01, b10, b11);
    ma[0][0] = 16'(a00); ma[0][1] = 16'(a01); ma[1][0] = 16'(a10); ma[1][1] = 16'(a11);
    mb[0][0] = 16'(b00); mb[0][1] = 16'(b01); mb[1][0] = 16'(b10); mb[1][1] = 16'(b11);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Starts a job once start_ready allows it; returns edges from accept to out_valid (-1 on timeout).
  task automatic run_job(input logic tr, input logic relu, output int lat);
    int w;
    w = 0;
    while (!start_ready && w < 40) begin tick(); w++; end
    start = 1'b1; transpose_req = tr; relu_req = relu;
    tick();
    start = 1'b0; transpose_req = 1'b0; relu_req = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (out_valid) begin lat = k; break; end
    end
  endtask

  task automatic check_res(input string name, input int e00, e01, e10, e11);
    n_tests++;
    if (res00 !== 16'(e00) || res01 !== 16'(e01) || res10 !== 16'(e10) || res11 !== 16'(e11)) begin
      n_fail++;
      $display("FAIL %s: res=(%0d,%0d,%0d,%0d) expected (%0d,%0d,%0d,%0d)", name,
               res00, res01, res10, res11, e00, e01, e10, e11);
    end
  endtask

  task automatic check_lat(input string name, input int lat, input int exp);
    n_tests++;
    if (lat !== exp) begin
      n_fail++;
      $display("FAIL %s: out_valid after %0d edges, expected %0d", name, lat, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_tests++;
    if ({clear, data_valid, transpose, activation, out_valid, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: clear,dv,tr,act,ov,busy=%b expected 000000",
               {clear, data_valid, transpose, activation, out_valid, busy});
    end
    n_tests++;
    if ({a0_sel, a1_sel, b0_sel, b1_sel} !== 8'hAA || start_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_sel: sels=%h start_ready=%b expected aa 1",
               {a0_sel, a1_sel, b0_sel, b1_sel}, start_ready);
    end
    check_res("reset_res", 0, 0, 0, 0);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp_sel [0:3];
    int lat;
    exp_sel[0] = 8'hAA; exp_sel[1] = 8'h22; exp_sel[2] = 8'h44; exp_sel[3] = 8'h99;
    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({a0_sel, a1_sel, b0_sel, b1_sel} !== exp_sel[k] ||
          clear !== (k == 0) || data_valid !== (k != 0)) begin
        n_fail++;
        $display("FAIL basic_seq%0d: sels=%h clear=%b dv=%b expected sels=%h", k,
                 {a0_sel, a1_sel, b0_sel, b1_sel}, clear, data_valid, exp_sel[k]);
      end
      if (k < 3) tick();
    end
    lat = -1;
    for (int k = 4; k <= 40; k++) begin
      tick();
      if (out_valid) begin lat = k; break; end
    end
    check_lat("basic_latency", lat, 6);
    check_res("basic_res", 19, 22, 43, 50);
  endtask

  task automatic test_transpose();
    int lat;
    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    run_job(1'b1, 1'b0, lat);
    check_lat("transpose_latency", lat, 6);
    check_res("transpose_res", 17, 23, 39, 53);
  endtask

  task automatic test_relu();
    int lat;
    set_mats(-1, 0, 0, -1, 5, 6, 7, 8);
    run_job(1'b0, 1'b1, lat);
    check_res("relu_res", 0, 0, 0, 0);
    n_tests++;
    if (activation !== 1'b1 || transpose !== 1'b0) begin
      n_fail++;
      $display("FAIL relu_flags: activation=%b transpose=%b expected 1 0", activation, transpose);
    end
  endtask

  task automatic test_stall();
    int lat, bad;
    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    run_job(1'b0, 1'b0, lat);
    check_lat("stall_latency", lat, 6);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      start = k[0];
      tick();
      if (start_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b1 ||
          res00 !== 16'sd19 || res11 !== 16'sd50) bad++;
    end
    start = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d bad cycles, expected 0", bad);
    end
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || clear !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: ov=%b clear=%b busy=%b expected 0 1 1", out_valid, clear, busy);
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (out_valid) begin lat = k; break; end
    end
    check_lat("stall_restart_latency", lat, 6);
  endtask

  task automatic test_back_to_back();
    int cnt;
    logic seen_low;
    out_ready = 1'b1;
    start = 1'b1;
    for (int j = 0; j < 2; j++) begin
      cnt = -1; seen_low = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        tick();
        if (seen_low && out_valid) begin cnt = k; break; end
        if (!out_valid) seen_low = 1'b1;
      end
      if (j == 1) start = 1'b0;
      check_lat("b2b_period", cnt, 7);
      check_res("b2b_res", 19, 22, 43, 50);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%b ov=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_midjob();
    int lat, seen;
    start = 1'b1; transpose_req = 1'b1; relu_req = 1'b1;
    tick();
    start = 1'b0; transpose_req = 1'b0; relu_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_tests++;
    if ({clear, data_valid, transpose, activation, out_valid, busy} !== 6'b0 ||
        {a0_sel, a1_sel, b0_sel, b1_sel} !== 8'hAA || start_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_ctrl: ctrl=%b sels=%h start_ready=%b expected 000000 aa 1",
               {clear, data_valid, transpose, activation, out_valid, busy},
               {a0_sel, a1_sel, b0_sel, b1_sel}, start_ready);
    end
    check_res("midreset_res", 0, 0, 0, 0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midreset_quiet: %0d cycles with out_valid/busy set, expected 0", seen);
    end
    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    run_job(1'b0, 1'b0, lat);
    check_lat("midreset_latency", lat, 6);
    check_res("midreset_res_after", 19, 22, 43, 50);
  endtask

  task automatic test_drain4();
    int lat, bad;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = -1; bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy4 !== 1'b1) bad++;
      start4 = (k >= 4 && k <= 6);
      tick();
      if (ov4) begin lat = k; break; end
    end
    start4 = 1'b0;
    check_lat("drain4_latency", lat, 8);
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL drain4_busy: %0d cycles with busy=0, expected 0", bad);
    end
    tick();
    n_tests++;
    if (busy4 !== 1'b0 || ov4 !== 1'b0 || start_ready4 !== 1'b1) begin
      n_fail++;
      $display("FAIL drain4_not_queued: busy=%b ov=%b start_ready=%b expected 0 0 1",
               busy4, ov4, start_ready4);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; transpose_req = 1'b0; relu_req = 1'b0;
    out_ready = 1'b1; start4 = 1'b0;
    set_mats(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_basic();
    test_transpose();
    test_relu();
    test_stall();
    test_back_to_back();
    test_reset_midjob();
    test_drain4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_sequencer_2x2.md
# systolic_sequencer_2x2

Control sequencer directly upstream of the 2x2 systolic array. It accepts a start request and runs one 2x2 matrix multiply: clear pulse, three skewed feed cycles of operand-select codes, then a drain period. It captures the four accumulator outputs into a result register and presents them downstream through a valid/ready handshake. Operands come straight from memory into the array; this block drives only the array's control pins.

## Interface
- DRAIN_CYCLES, 2: cycles after the last feed cycle before capture; minimum 2.
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  request one multiply; honoured only while start_ready=1
- transpose_req  in  1  transpose B for this job; latched when start is accepted
- relu_req  in  1  apply ReLU for this job; latched when start is accepted
- start_ready  out  1  state==IDLE && (!out_valid || out_ready)
- busy  out  1  state != IDLE
- clear  out  1  to array: zero the accumulators
- data_valid  out  1  to array: operand buses are live
- a0_sel, a1_sel, b0_sel, b1_sel  out  2 each  to array: operand select; 2'd2 = zero
- transpose, activation  out  1 each  to array: latched job flags
- c00, c01, c10, c11  in  16 signed each  from array: accumulator outputs (ReLU already applied)
- res00, res01, res10, res11  out  16 signed each  captured result
- out_valid  out  1  result registered and pending
- out_ready  in  1  downstream accepts the result

## Operation
- States: IDLE, CLEAR, FEED0, FEED1, FEED2, DRAIN, CAPTURE.
- IDLE -> CLEAR on start && start_ready. transpose_req and relu_req are latched into transpose and activation on the same edge.
- CLEAR: clear=1, data_valid=0, all selects 2. Moves to FEED0.
- The feed states set data_valid=1 with the following select codes (a0, a1, b0, b1):
  - FEED0: 0, 2, 0, 2
  - FEED1: 1, 0, 1, 0
  - FEED2: 2, 1, 2, 1
- FEED0 -> FEED1 -> FEED2 -> DRAIN, one cycle each.
- DRAIN: data_valid=0, selects 2. A down-counter is loaded with DRAIN_CYCLES-1 on entry. Move to CAPTURE when it reaches 0.
- CAPTURE (one cycle): res* <= c*, out_valid <= 1. Moves to IDLE.
- out_valid clears on an edge with out_valid && out_ready, except when the CAPTURE edge sets it.
- transpose and activation hold their values until the next accepted start, so ReLU stays stable through capture.
- Outside CLEAR and the FEED states: clear=0, data_valid=0, all selects=2.

## Timing
- Reset (rst=0 at an edge): state=IDLE, counter=0. Outputs:
  - clear, data_valid, transpose, activation, out_valid, busy: 0
  - res*: 0
  - selects: 2
  - start_ready: 1
- Reset mid-job aborts with no capture. The next job's CLEAR re-zeroes the array.
- Latency: start accepted at edge E. out_valid rises at edge E+4+DRAIN_CYCLES, which is E+6 at the default.
- Justification for DRAIN_CYCLES >= 2: the last product reaches PE11 at the first DRAIN edge and is visible on c11 in the following cycle.
- Back-to-back: with out_ready held high, a new start is accepted in the first IDLE cycle after CAPTURE. Throughput is one job per 5+DRAIN_CYCLES cycles.
- Simultaneous out_valid && out_ready && start in IDLE: the result is consumed and the new job starts on the same edge.
- start while busy, or while out_valid && !out_ready: ignored and not queued.
- res* are stable while out_valid=1. They change only at CAPTURE.

## Structure
- Shared package tpu_pkg holds:
  - the state encoding (3-bit enum)
  - SEL_W0/SEL_W1/SEL_ZERO (2'd0/2'd1/2'd2)
  - ACC_W=16
- Single module with no sub-module. The result register plus out_valid is simple enough to keep inline.

## Test plan
- Reset then start with transpose_req=0, relu_req=0. Check:
  - select sequence (0,2,0,2), (1,0,1,0), (2,1,2,1) on three consecutive cycles after a one-cycle clear
  - out_valid at E+6
  - with weights 1,2,3,4 and inputs 5,6,7,8 through a PE model: res = 19, 22, 43, 50
- Same job with transpose_req=1: res00=1*5+2*6=17, res01=1*7+2*8=23, res10=39, res11=53.
- relu_req=1 with weights -1,0,0,-1 and inputs 5,6,7,8: res00=res01=res10=res11=0, and activation is held at 1 through capture.
- out_ready=0 after completion:
  - start pulses are ignored, start_ready=0, res* are unchanged for 10 cycles
  - raising out_ready together with start drops out_valid and begins CLEAR on the same edge
- rst=0 asserted during FEED1: next cycle all outputs are at reset values and out_valid never rises. A following job still yields 19, 22, 43, 50.
- DRAIN_CYCLES=4: out_valid at E+8. start during DRAIN is ignored and busy=1 throughout.
